// File: rtl/board_io_ctrl.sv
// board_io_ctrl: switch/button synchronizers, button debounce with press pulses,
// and a registered multiplexed 7-segment scanner.
module board_io_ctrl #(
  parameter int NUM_SW          = 16,
  parameter int NUM_BTN         = 5,
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REFRESH_CYCLES  = 100_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_SW-1:0]       sw_in,
  input  logic [NUM_BTN-1:0]      btn_in,
  output logic [NUM_SW-1:0]       sw_out,
  output logic [NUM_BTN-1:0]      btn_level,
  output logic [NUM_BTN-1:0]      btn_press,
  input  logic [4*NUM_DIGITS-1:0] disp_value,
  input  logic [NUM_DIGITS-1:0]   disp_en,
  input  logic [NUM_DIGITS-1:0]   disp_dp,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [DW-1:0] DG_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic [NUM_SW-1:0]     r_sw_s1, r_sw_s2;
  logic [NUM_BTN-1:0]    r_btn_s1, r_btn_s2, r_level, r_press;
  logic [CW-1:0]         r_cnt [NUM_BTN];
  logic [RW-1:0]         r_ref;
  logic [DW-1:0]         r_digit;
  logic [NUM_DIGITS-1:0] r_an;
  logic [6:0]            r_seg;
  logic                  r_dp;
  logic [3:0]            w_nib;
  logic                  w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
    end else begin
      r_sw_s1  <= sw_in;
      r_sw_s2  <= r_sw_s1;
      r_btn_s1 <= btn_in;
      r_btn_s2 <= r_btn_s1;
    end
  end

  // Counter runs only while the synchronized bit disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '{default: '0};
      r_level <= '0;
      r_press <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        r_press[i] <= 1'b0;
        if (r_btn_s2[i] == r_level[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == DB_LAST) begin
          r_cnt[i]   <= '0;
          r_level[i] <= r_btn_s2[i];
          r_press[i] <= r_btn_s2[i];
        end else r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_nib = disp_value[{r_digit, 2'b00} +: 4];
  assign w_en  = disp_en[r_digit];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ref   <= '0;
      r_digit <= '0;
      r_an    <= '1;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      r_ref <= r_ref == RF_LAST ? '0 : r_ref + 1'b1;
      if (r_ref == RF_LAST) r_digit <= r_digit == DG_LAST ? '0 : r_digit + 1'b1;
      r_an  <= w_en ? ~(NUM_DIGITS'(1) << r_digit) : '1;
      r_seg <= w_en ? HEX[w_nib] : 7'h7F;
      r_dp  <= ~(w_en & disp_dp[r_digit]);
    end
  end

  assign sw_out    = r_sw_s2;
  assign btn_level = r_level;
  assign btn_press = r_press;
  assign an        = r_an;
  assign seg       = r_seg;
  assign dp        = r_dp;
endmodule

// File: tb/tb_board_io_ctrl.sv
// tb_board_io_ctrl: directed and random stimulus against a sample-history reference model.
module tb_board_io_ctrl;
  localparam int NSW = 16, NB = 5, ND = 4, DB = 4, RC = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSW-1:0]  sw_in, sw_out;
  logic [NB-1:0]   btn_in, btn_level, btn_press;
  logic [4*ND-1:0] disp_value;
  logic [ND-1:0]   disp_en, disp_dp, an;
  logic [6:0]      seg;
  logic            dp;

  always #5 clk = ~clk;

  board_io_ctrl #(
    .NUM_SW(NSW), .NUM_BTN(NB), .NUM_DIGITS(ND),
    .DEBOUNCE_CYCLES(DB), .REFRESH_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .btn_in(btn_in),
    .sw_out(sw_out), .btn_level(btn_level), .btn_press(btn_press),
    .disp_value(disp_value), .disp_en(disp_en), .disp_dp(disp_dp),
    .seg(seg), .an(an), .dp(dp)
  );

  logic [6:0] hex7 [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_chk = 0, n_pass = 0;
  logic [NSW-1:0] swq[$];
  logic [NB-1:0]  bq[$];
  logic [NB-1:0]  win[$];
  logic [NB-1:0]  m_level = '0, m_press = '0;
  int             nsc = 0;
  int             hold [NB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Raw samples since reset stand in for the synchronizers; the debounced level flips
  // once the last DB synchronized samples all disagree with it.
  task automatic step(input logic r);
    logic [NB-1:0]  s2pre;
    logic [NSW-1:0] e_sw;
    logic [ND-1:0]  e_an;
    logic [6:0]     e_seg;
    logic           e_dp, all;
    int             k;
    rst = r;
    @(posedge clk);
    if (r) begin
      swq.delete(); bq.delete(); win.delete();
      m_level = '0; m_press = '0; nsc = 0;
    end else begin
      s2pre = bq.size() >= 2 ? bq[bq.size()-2] : '0;
      swq.push_back(sw_in);
      bq.push_back(btn_in);
      while (swq.size() > 2) void'(swq.pop_front());
      while (bq.size() > 2) void'(bq.pop_front());
      win.push_back(s2pre);
      while (win.size() > DB) void'(win.pop_front());
      m_press = '0;
      for (int i = 0; i < NB; i++) begin
        if (win.size() == DB) begin
          all = 1'b1;
          foreach (win[j]) if (win[j][i] == m_level[i]) all = 1'b0;
          if (all) begin
            m_level[i] = ~m_level[i];
            m_press[i] = m_level[i];
          end
        end
      end
      nsc++;
    end
    e_sw = swq.size() >= 2 ? swq[0] : '0;
    if (r) begin
      e_an = '1; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      k = ((nsc - 1) / RC) % ND;
      e_an  = disp_en[k] ? ~(ND'(1) << k) : '1;
      e_seg = disp_en[k] ? hex7[disp_value[4*k +: 4]] : 7'h7F;
      e_dp  = disp_en[k] ? ~disp_dp[k] : 1'b1;
    end
    #1;
    chk("sw_out", 32'(sw_out), 32'(e_sw));
    chk("btn_level", 32'(btn_level), 32'(m_level));
    chk("btn_press", 32'(btn_press), 32'(m_press));
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("an_one_low", 32'($countones(~an) <= 1), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    sw_in = '0; btn_in = '0;
    disp_value = 16'h8F10; disp_en = 4'hF; disp_dp = 4'b0100;
    #2;
    // reset state
    step(1'b1);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_level", 32'(btn_level), 32'd0);
    chk("rst_press", 32'(btn_press), 32'd0);
    chk("rst_sw", 32'(sw_out), 32'd0);

    // held button: level rises on the 6th edge, one press pulse only
    btn_in[0] = 1'b1;
    sw_in = 16'hA5C3;
    for (int c = 1; c <= 12; c++) begin
      step(1'b0);
      if (c == 2) chk("sw_latency", 32'(sw_out), 32'hA5C3);
      if (c == 5) chk("held_lvl5", 32'(btn_level[0]), 32'd0);
      if (c == 6) chk("held_lvl6", 32'(btn_level[0]), 32'd1);
      if (c == 6) chk("held_press6", 32'(btn_press[0]), 32'd1);
      if (c == 7) chk("held_press7", 32'(btn_press[0]), 32'd0);
    end
    // full scan over the same 12 cycles
    btn_in[0] = 1'b0;
    step(1'b1);
    for (int c = 1; c <= 12; c++) begin
      step(1'b0);
      if (c == 1) chk("scan_d0", 32'({an, seg}), 32'({4'b1110, 7'h40}));
      if (c == 4) chk("scan_d1", 32'({an, seg}), 32'({4'b1101, 7'h79}));
      if (c == 7) chk("scan_d2", 32'({an, seg, dp}), 32'({4'b1011, 7'h0E, 1'b0}));
      if (c == 12) chk("scan_d3", 32'({an, seg, dp}), 32'({4'b0111, 7'h00, 1'b1}));
    end

    // bounce rejection: 3 high, 2 low, five times
    step(1'b1);
    for (int rep = 0; rep < 5; rep++) begin
      btn_in[0] = 1'b1;
      repeat (3) step(1'b0);
      btn_in[0] = 1'b0;
      repeat (2) step(1'b0);
    end
    repeat (4) step(1'b0);
    chk("bounce_lvl", 32'(btn_level), 32'd0);

    // blanking of digit 1
    disp_en = 4'b1101;
    step(1'b1);
    for (int c = 1; c <= 12; c++) begin
      step(1'b0);
      if (c == 5) chk("blank_d1", 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
    end

    // reset during digit-2 dwell while button 1 is mid-debounce
    disp_en = 4'hF;
    step(1'b1);
    repeat (4) step(1'b0);
    btn_in[1] = 1'b1;
    repeat (3) step(1'b0);
    step(1'b1);
    chk("midrst_an", 32'(an), 32'hF);
    for (int c = 1; c <= 7; c++) begin
      step(1'b0);
      if (c <= 3) chk("midrst_d0", 32'(an), 32'b1110);
      if (c == 5) chk("midrst_lvl5", 32'(btn_level[1]), 32'd0);
      if (c == 6) chk("midrst_lvl6", 32'(btn_level[1]), 32'd1);
    end
    btn_in = '0;

    // random phase
    foreach (hold[i]) hold[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (hold[i] == 0) begin
          btn_in[i] = 1'($urandom);
          hold[i] = $urandom_range(1, 8);
        end
        hold[i]--;
      end
      sw_in = 16'($urandom);
      if ($urandom_range(0, 7) == 0) disp_value = 16'($urandom);
      if ($urandom_range(0, 7) == 0) disp_en = 4'($urandom);
      if ($urandom_range(0, 7) == 0) disp_dp = 4'($urandom);
      step($urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/board_io_ctrl.md
BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_SW, default 16: number of slide-switch inputs.
REQ-002 SHALL have parameter NUM_BTN, default 5: number of push-button inputs.
REQ-003 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits; legal values are 1 or more.
REQ-004 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000: number of consecutive stable cycles required to accept a button change; legal values are 1 or more.
REQ-005 SHALL have parameter REFRESH_CYCLES, default 100_000: dwell time of each digit in cycles; legal values are 1 or more.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port sw_in, input, NUM_SW bits: raw asynchronous switches.
REQ-009 SHALL have port btn_in, input, NUM_BTN bits: raw asynchronous buttons.
REQ-010 SHALL have port sw_out, output, NUM_SW bits: synchronized switches.
REQ-011 SHALL have port btn_level, output, NUM_BTN bits: debounced button levels.
REQ-012 SHALL have port btn_press, output, NUM_BTN bits: one-cycle rising-edge pulse per button.
REQ-013 SHALL have port disp_value, input, 4*NUM_DIGITS bits: hex nibbles, with digit i at bits [4i+3:4i].
REQ-014 SHALL have port disp_en, input, NUM_DIGITS bits: per-digit enable; a disabled digit is blanked.
REQ-015 SHALL have port disp_dp, input, NUM_DIGITS bits: per-digit decimal point request.
REQ-016 SHALL have port seg, output, 7 bits: cathodes, active-low, seg[6:0] = {g,f,e,d,c,b,a}.
REQ-017 SHALL have port an, output, NUM_DIGITS bits: anodes, active-low.
REQ-018 SHALL have port dp, output, 1 bit: decimal point, active-low.

Function
REQ-019 SHALL pass each sw_in and btn_in bit through a 2-flop synchronizer; sw_out is the second stage, giving 2-cycle latency.
REQ-020 SHALL give each button an independent debounce counter of width $clog2(DEBOUNCE_CYCLES+1), behaving as follows:
- while the synchronized bit equals btn_level, the counter clears to 0;
- while it differs, the counter increments.
REQ-021 SHALL load the synchronized value into btn_level and clear the counter on the DEBOUNCE_CYCLES-th consecutive differing edge; raw-input-to-btn_level latency is therefore DEBOUNCE_CYCLES+2 edges.
REQ-022 SHALL reject any input pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles: btn_level is unchanged and the counter returns to 0.
REQ-023 SHALL assert btn_press[i] for exactly one cycle, coincident with the first cycle btn_level[i] reads 1; a 1->0 transition produces no pulse.
REQ-024 SHALL keep a refresh counter running 0..REFRESH_CYCLES-1; when it wraps, the digit index advances modulo NUM_DIGITS (NUM_DIGITS-1 wraps to 0).
REQ-025 SHALL register seg, an and dp every edge from the pre-edge digit index k and the current disp_value, disp_en and disp_dp, giving 1-cycle latency:
- if disp_en[k]=1: an has only bit k low, seg = hex-decode(nibble k), dp = ~disp_dp[k];
- if disp_en[k]=0: an = all 1s, seg = 7'h7F, dp = 1.
REQ-026 SHALL use this hex decode (active-low):
- 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78;
- 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
REQ-027 SHALL drive at most one an bit low in any cycle.
REQ-028 SHALL reflect a change to disp_value, disp_en or disp_dp mid-dwell on the next edge, with no effect on scan timing.
REQ-029 SHALL give each digit a dwell of exactly REFRESH_CYCLES cycles; with REFRESH_CYCLES=1, the digit advances every cycle.

Reset
REQ-030 SHALL, on any edge with rst=1, clear synchronizers, sw_out, btn_level, btn_press, debounce counters, refresh counter and digit index to 0, and set an to all 1s, seg to 7'h7F and dp to 1.
REQ-031 SHALL let rst override all other activity, including mid-debounce and mid-dwell; the scan restarts at digit 0 with a full dwell after rst falls.
REQ-032 SHALL produce no btn_press pulse as a result of reset.

Verification (NUM_DIGITS=4, DEBOUNCE_CYCLES=4, REFRESH_CYCLES=3)
REQ-033 SHALL cover reset: rst high for one edge -> an=4'hF, seg=7'h7F, dp=1, btn_level=0, btn_press=0, sw_out=0.
REQ-034 SHALL cover a held button: btn_in[0] held 1 from edge 0 -> btn_level[0]=1 after edge 6; btn_press[0]=1 for only the cycle after edge 6; no further pulse while held.
REQ-035 SHALL cover bounce rejection: btn_in[0] high for 3 cycles, low for 2, repeated 5 times -> btn_level[0] stays 0 and btn_press stays 0.
REQ-036 SHALL cover a full scan: disp_value=16'h8F10, disp_en=4'hF, disp_dp=4'b0100 ->
- an cycles 1110, 1101, 1011, 0111, 3 cycles each;
- seg = 40, 79, 0E, 00 respectively;
- dp is low only while an=1011.
REQ-037 SHALL cover blanking: disp_en=4'b1101 -> during the digit-1 slot, an=4'hF, seg=7'h7F, dp=1; other slots are as in REQ-036.
REQ-038 SHALL cover reset mid-operation: rst asserted during the digit-2 dwell and mid-debounce -> reset outputs on the next edge; after release, digit 0 is shown for 3 cycles and the debounce count restarts from 0.
